// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one iterative 32x32 multiplier with done qualification and timeout.
// Define MUL_SIGNED_EN for signed operations (magnitude issue, negate in an extra stage).
module mul_share_ctrl #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_signed,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [63:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [63:0]           mul_result,
    input  logic                  mul_done
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [2:0] {IDLE, ISSUE, START, WAIT, FIX, RESP} state_t;

    state_t        state;
    logic [GW-1:0] last, g, idx, sel;
    logic          found, done_seen_low, sgn_q, neg_q, sgn_in, neg_in;
    logic [CW-1:0] cnt;
    logic [31:0]   a_raw, b_raw, a_in, b_in;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(last) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE && found) ? ONE << sel : '0;
    assign a_raw     = req_a[32*sel +: 32];
    assign b_raw     = req_b[32*sel +: 32];

`ifdef MUL_SIGNED_EN
    assign sgn_in = req_signed[sel];
`else
    logic unused_signed;
    assign unused_signed = ^req_signed;
    assign sgn_in = 1'b0;
`endif

    // magnitudes go to the unsigned multiplier; 0x80000000 maps onto itself
    assign neg_in = sgn_in & (a_raw[31] ^ b_raw[31]);
    assign a_in   = (sgn_in & a_raw[31]) ? -a_raw : a_raw;
    assign b_in   = (sgn_in & b_raw[31]) ? -b_raw : b_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last          <= GW'(N_REQ - 1);
            g             <= '0;
            sgn_q         <= 1'b0;
            neg_q         <= 1'b0;
            done_seen_low <= 1'b0;
            cnt           <= '0;
            rsp_valid     <= '0;
            rsp_result    <= '0;
            rsp_err       <= 1'b0;
            mul_start     <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    g     <= sel;
                    last  <= sel;
                    mul_a <= a_in;
                    mul_b <= b_in;
                    sgn_q <= sgn_in;
                    neg_q <= neg_in;
                    state <= ISSUE;
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    done_seen_low <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: if (mul_done && done_seen_low) begin
                    rsp_result <= mul_result;
                    rsp_err    <= 1'b0;
                    mul_start  <= 1'b0;
                    rsp_valid  <= sgn_q ? '0 : ONE << g;
                    state      <= sgn_q ? FIX : RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                    mul_start  <= 1'b0;
                    rsp_valid  <= ONE << g;
                    state      <= RESP;
                end else begin
                    cnt           <= cnt + 1'b1;
                    done_seen_low <= done_seen_low | !mul_done;
                end
                FIX: begin
                    rsp_result <= neg_q ? -rsp_result : rsp_result;
                    rsp_valid  <= ONE << g;
                    state      <= RESP;
                end
                RESP: if (|(rsp_valid & rsp_ready)) begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed bench with a 32-step multiplier model for mul_share_ctrl.
module tb_mul_share_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   req_valid = '0, req_ready, req_signed = '0, rsp_valid, rsp_ready = '0;
    logic [63:0]  req_a = '0, req_b = '0, rsp_result, mul_result;
    logic         rsp_err, mul_start, mul_done;
    logic [31:0]  mul_a, mul_b;
    int           checks = 0, failures = 0, mode = 0;

    logic         start_q = 1'b0, mbusy = 1'b0, mdone = 1'b0;
    logic [63:0]  mres = '0;
    int           mcnt = 0;

`ifdef MUL_SIGNED_EN
    localparam logic [63:0] EXP_NEG = 64'hFFFFFFFFFFFFFFF1;
    localparam logic [31:0] EXP_MAG = 32'd3;
    localparam int          LAT_S   = 37;
`else
    localparam logic [63:0] EXP_NEG = 64'h00000004FFFFFFF1;
    localparam logic [31:0] EXP_MAG = 32'hFFFFFFFD;
    localparam int          LAT_S   = 36;
`endif

    always #5 clk = ~clk;

    // multiplier model: not reset, relaunched by a rising start, done held until the next launch
    always @(posedge clk) begin
        start_q <= mul_start;
        if (mul_start && !start_q) begin
            mbusy <= 1'b1;
            mcnt  <= 0;
            mdone <= 1'b0;
        end else if (mbusy) begin
            mcnt <= mcnt + 1;
            if (mcnt == 32) begin
                mdone <= 1'b1;
                mres  <= {32'd0, mul_a} * {32'd0, mul_b};
                mbusy <= 1'b0;
            end
        end
    end

    assign mul_done   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : mdone;
    assign mul_result = mres;

    mul_share_ctrl #(.N_REQ(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_valid[i]     = 1'b1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_signed[i]    = s;
    endtask

    task automatic accept(input int i);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int n);
        n = 0;
        while (rsp_valid[i] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(input int i);
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_result !== 64'd0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_result, rsp_err); end
        checks++; if (mul_start !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin failures++; $display("FAIL reset_mul got=%b/%h/%h exp=0/0/0", mul_start, mul_a, mul_b); end
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_req_ready got=%b exp=00", req_ready); end
    endtask

    task automatic test_single;
        int n;
        drive(0, 32'd7, 32'd6, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        accept(0);
        checks++; if (mul_a !== 32'd7 || mul_b !== 32'd6 || mul_start !== 1'b0) begin failures++; $display("FAIL single_issue got=%h/%h/%b exp=7/6/0", mul_a, mul_b, mul_start); end
        wait_rsp(0, n);
        checks++; if (n !== 36) begin failures++; $display("FAIL single_latency got=%0d exp=36", n); end
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_result !== 64'd42 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_result got=%h/%b exp=42/0", rsp_result, rsp_err); end
        handshake(0);
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_rsp_drop got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_round_robin;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            drive(0, 32'd3, 32'd4, 1'b0);
            drive(1, 32'd5, 32'd6, 1'b0);
            #1;
            checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_first_grant round=%0d got=%b exp=01", r, req_ready); end
            accept(0);
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_busy_ready round=%0d got=%b exp=00", r, req_ready); end
            wait_rsp(0, n);
            checks++; if (rsp_result !== 64'd12 || rsp_valid !== 2'b01) begin failures++; $display("FAIL rr_rsp0 round=%0d got=%h/%b exp=12/01", r, rsp_result, rsp_valid); end
            handshake(0);
            checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_second_grant round=%0d got=%b exp=10", r, req_ready); end
            accept(1);
            wait_rsp(1, n);
            checks++; if (n !== 36 || rsp_result !== 64'd30 || rsp_valid !== 2'b10) begin failures++; $display("FAIL rr_rsp1 round=%0d got=%0d/%h/%b exp=36/30/10", r, n, rsp_result, rsp_valid); end
            handshake(1);
        end
    endtask

    task automatic test_boundaries;
        int n;
        drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        accept(0);
        wait_rsp(0, n);
        checks++; if (rsp_result !== 64'hFFFFFFFE00000001) begin failures++; $display("FAIL max_product got=%h exp=fffffffe00000001", rsp_result); end
        handshake(0);
        drive(0, 32'd0, 32'h12345678, 1'b0);
        accept(0);
        wait_rsp(0, n);
        checks++; if (rsp_result !== 64'd0 || rsp_err !== 1'b0) begin failures++; $display("FAIL zero_product got=%h/%b exp=0/0", rsp_result, rsp_err); end
        handshake(0);
    endtask

    task automatic test_backpressure;
        int n, bad;
        drive(0, 32'd11, 32'd13, 1'b0);
        accept(0);
        wait_rsp(0, n);
        drive(1, 32'd2, 32'd3, 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b01 || rsp_result !== 64'd143 || req_ready !== 2'b00) begin failures++; $display("FAIL hold cycle=%0d got=%b/%h/%b exp=01/8f/00", c, rsp_valid, rsp_result, req_ready); end
        end
        handshake(0);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL hold_next_grant got=%b exp=10", req_ready); end
        accept(1);
        wait_rsp(1, n);
        checks++; if (rsp_result !== 64'd6 || rsp_valid !== 2'b10) begin failures++; $display("FAIL hold_rsp1 got=%h/%b exp=6/10", rsp_result, rsp_valid); end
        handshake(1);
    endtask

    task automatic test_timeout;
        int n;
        for (int m = 1; m <= 2; m++) begin
            mode = m;
            drive(0, 32'd5, 32'd5, 1'b0);
            accept(0);
            wait_rsp(0, n);
            checks++; if (n !== 66) begin failures++; $display("FAIL timeout_latency mode=%0d got=%0d exp=66", m, n); end
            checks++; if (rsp_err !== 1'b1 || rsp_result !== 64'd0 || rsp_valid !== 2'b01) begin failures++; $display("FAIL timeout_rsp mode=%0d got=%b/%h/%b exp=1/0/01", m, rsp_err, rsp_result, rsp_valid); end
            handshake(0);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid;
        int n;
        drive(0, 32'd100, 32'd200, 1'b0);
        accept(0);
        repeat (10) @(negedge clk);
        checks++; if (mul_start !== 1'b1 || mul_a !== 32'd100) begin failures++; $display("FAIL mid_wait got=%b/%h exp=1/64", mul_start, mul_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mul_start !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL async_reset got=%b/%h/%h/%b/%b exp=all zero", mul_start, mul_a, mul_b, rsp_valid, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 32'd9, 32'd9, 1'b0);
        accept(0);
        wait_rsp(0, n);
        checks++; if (n !== 36 || rsp_result !== 64'd81 || rsp_err !== 1'b0) begin failures++; $display("FAIL after_reset got=%0d/%h/%b exp=36/51/0", n, rsp_result, rsp_err); end
        handshake(0);
    endtask

    task automatic test_signed;
        int n;
        drive(0, 32'hFFFFFFFD, 32'd5, 1'b1);
        accept(0);
        checks++; if (mul_a !== EXP_MAG || mul_b !== 32'd5) begin failures++; $display("FAIL signed_operands got=%h/%h exp=%h/5", mul_a, mul_b, EXP_MAG); end
        wait_rsp(0, n);
        checks++; if (n !== LAT_S) begin failures++; $display("FAIL signed_latency got=%0d exp=%0d", n, LAT_S); end
        checks++; if (rsp_result !== EXP_NEG) begin failures++; $display("FAIL signed_result got=%h exp=%h", rsp_result, EXP_NEG); end
        handshake(0);
        drive(0, 32'h80000000, 32'h80000000, 1'b1);
        accept(0);
        checks++; if (mul_a !== 32'h80000000) begin failures++; $display("FAIL min_operand got=%h exp=80000000", mul_a); end
        wait_rsp(0, n);
        checks++; if (rsp_result !== 64'h4000000000000000) begin failures++; $display("FAIL min_product got=%h exp=4000000000000000", rsp_result); end
        handshake(0);
        req_signed = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundaries();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_signed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
